dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the MIPS core's data/instruction memory port. It accepts one
//  request at a time over a valid/ready handshake and applies a programmable wait-state
//  latency. Word storage has byte-enable writes; each transaction ends in a response beat
//  (read data or write ack). Serves as the far end of the core's load/store interface in
//  multicycle/stall-capable builds.
// PARAMETERS
//  ADDR_WIDTH  6  log2 of depth in 32-bit words (64 words = 256 B)
//  LATENCY     2  wait cycles between request accept and response valid (0..15)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept request this cycle
//  req_we     in   1   1 = write, 0 = read
//  req_addr   in   32  byte address
//  req_wdata  in   32  write data
//  req_be     in   4   byte enables, bit i -> wdata[8i+7:8i]
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   initiator accepts response
//  rsp_rdata  out  32  read data (0 for writes and errors)
//  rsp_err    out  1   request was misaligned or out of range
// BEHAVIOUR
//  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait cnt=0.
//    Memory contents are not reset.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//      IDLE: req_ready=1. Accept on req_valid&&req_ready; latch we/addr/wdata/be.
//            Go to WAIT with cnt=LATENCY-1, or go directly to RESP if LATENCY==0.
//      WAIT: req_ready=0. cnt decrements each cycle; at cnt==0 go to RESP.
//      RESP: rsp_valid=1, and rsp_rdata/rsp_err stay stable until rsp_valid&&rsp_ready.
//            On that handshake go to IDLE.
//  - Response ordering and throughput:
//      rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
//      req_ready returns 1 the cycle after the response handshake; no same-cycle bypass.
//      Peak throughput is 1 transaction per LATENCY+2 cycles.
//  - Commit point: the write and the read sample occur on the edge that enters RESP.
//    Reads return post-write contents of all earlier transactions.
//  - Addressing: word index = addr[ADDR_WIDTH+1:2].
//      err = (addr[1:0]!=0) || (addr[31:ADDR_WIDTH+2]!=0).
//      On err: no array write, rdata=0, rsp_err=1.
//  - Writes: only lanes with be[i]=1 change. be=4'b0000 is a legal no-op write and is still acked.
//    Write response has rdata=0, err per above.
//  - Reads ignore req_be and return the full word.
//  - Backpressure: rsp_ready low in RESP holds every output indefinitely.
//    No new request is accepted until the handshake completes.
//  - Request inputs are ignored outside IDLE. A req_valid held across the response is
//    accepted again as a new transaction once IDLE is re-entered.
//  - Reset mid-operation: any state returns to IDLE immediately.
//      A write accepted but not yet committed is dropped.
//      A pending response is discarded.
// STRUCTURE
//  - Package mips_mem_pkg holds:
//      typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t
//      localparam WORD_BYTES = 4
//      typedef logic [31:0] word_t
//  - Sub-module dmem_array #(ADDR_WIDTH): synchronous byte-enable write port and
//    combinational read of one word, no reset.
//  - Top level holds the FSM, wait counter, request latch and error check.
// TESTING
//  1. Reset, then write addr=0x10 data=0xDEADBEEF be=F, then read 0x10.
//     -> rdata=0xDEADBEEF, err=0, rsp_valid exactly 3 cycles after each accept (LATENCY=2).
//  2. Partial write: after test 1, write 0x10 data=0x000000AA be=4'b0001, then read.
//     -> 0xDEADBEAA. A be=0 write leaves the word unchanged.
//  3. Errors: read 0x12 -> err=1, rdata=0. Write 0x100 (ADDR_WIDTH=6) -> err=1, no word changed.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
//     -> outputs stable, req_ready=0. Then one handshake, and req_ready=1 the next cycle.
//  5. LATENCY=0 build: back-to-back reads with req_valid and rsp_ready held high.
//     -> one response every 2 cycles, in order.
//  6. Assert reset during WAIT of a write to 0x20 (pre-value 0x11111111).
//     -> rsp_valid never rises, req_ready=1 after reset, later read of 0x20 = 0x11111111.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory-side responder: FSM states, word type and
// the byte-lane merge used by the storage array.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  localparam int WORD_BYTES = 4;

  typedef logic [31:0] word_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input logic [WORD_BYTES-1:0] be);
    word_t res;
    res = old_w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enable write, combinational read of
// the addressed word. Contents are deliberately not reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  word_t                 wdata,
  input  logic [WORD_BYTES-1:0] be,
  output word_t                 rdata
);

  word_t mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merge_bytes(mem[addr], wdata, be);
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one request at a time over valid/ready, a programmable
// wait-state latency, byte-enable word storage and a held response beat.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0] req_be,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic       rsp_err,
  output mem_state_t dbg_state
);

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready. Once
  // rsp_valid is high, rsp_rdata/rsp_err are held until that transfer.

  localparam logic [3:0] LAT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  mem_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       commit;

  logic       lat_we;
  word_t      lat_addr, lat_wdata;
  logic [3:0] lat_be;

  logic       cur_we;
  word_t      cur_addr, cur_wdata;
  logic [3:0] cur_be;
  logic       cur_err;
  word_t      arr_rdata;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  // With zero latency the commit happens on the accept edge, so the live
  // request fields are used instead of the latched copy.
  assign cur_we    = (state == IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign cur_be    = (state == IDLE) ? req_be    : lat_be;

  assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:ADDR_WIDTH+2] != '0);

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (commit && cur_we && !cur_err),
    .addr  (cur_addr[ADDR_WIDTH+1:2]),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = LAT_LAST;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= 4'd0;
    end else if (state == IDLE && req_valid) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // Response beat is captured on the commit edge and cleared once delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (!cur_we && !cur_err) ? arr_rdata : '0;
      rsp_err   <= cur_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array model,
// with a second zero-latency instance for streaming throughput.
module tb_dmem_responder;
  import mips_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  mem_state_t  dbg_state;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;
  mem_state_t  z_dbg_state;

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q[$];
  logic [31:0] exp_err_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd256);
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int bp);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat;
    int          w;
    exp_er = addr_err(addr);
    exp_rd = (!we && !exp_er) ? ref_mem[addr[7:2]] : 32'd0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    chk("ready_in_resp", 32'(req_ready), 32'd0);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(exp_er));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(exp_er));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_hs", 32'(req_ready), 32'd1);
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);
    if (we && !exp_er) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] zd [4];
    logic        t_we [9];
    logic [31:0] t_addr [9];
    logic [31:0] t_wd [9];
    int          idx, cyc, last_t;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;

    // Full write then read back.
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    // Partial write, then a no-op write with be=0.
    run_txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
    chk("partial_write_model", ref_mem[4], 32'hDEADBEAA);
    run_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    run_txn(1'b0, 32'h10, 32'h0, 4'h3, 0);

    // Fill every word so later reads have known contents.
    for (int i = 0; i < 64; i++) run_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

    // Misaligned read, out-of-range write, then confirm word 0 untouched.
    run_txn(1'b0, 32'h12, 32'h0, 4'hF, 0);
    run_txn(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 0);
    run_txn(1'b0, 32'h0, 32'h0, 4'hF, 0);

    // Backpressure for 5 cycles in RESP.
    run_txn(1'b0, 32'h10, 32'h0, 4'hF, 5);

    // Reset during WAIT of a write.
    run_txn(1'b1, 32'h20, 32'h11111111, 4'hF, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("state_wait_before_reset", 32'(dbg_state), 32'(WAIT));
    reset = 1'b1;
    #1;
    chk("reset_mid_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_mid_ready", 32'(req_ready), 32'd1);
    chk("reset_mid_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
      chk("ready_after_reset", 32'(req_ready), 32'd1);
    end
    run_txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
    chk("dropped_write_model", ref_mem[8], 32'h11111111);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 63)) * 4;
      case ($urandom_range(0, 7))
        0: a = a | 32'($urandom_range(1, 3));
        1: a = a | (32'd1 << $urandom_range(8, 31));
        default: ;
      endcase
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
    end

    // Zero-latency streaming: valid and rsp_ready held high.
    for (int i = 0; i < 4; i++) begin
      zd[i]     = $urandom;
      t_we[i]   = 1'b1;
      t_addr[i] = 32'h40 + 32'(i * 4);
      t_wd[i]   = zd[i];
    end
    t_we[4] = 1'b0; t_addr[4] = 32'h4C; t_wd[4] = 32'h0;
    t_we[5] = 1'b0; t_addr[5] = 32'h40; t_wd[5] = 32'h0;
    t_we[6] = 1'b0; t_addr[6] = 32'h48; t_wd[6] = 32'h0;
    t_we[7] = 1'b0; t_addr[7] = 32'h44; t_wd[7] = 32'h0;
    t_we[8] = 1'b0; t_addr[8] = 32'h41; t_wd[8] = 32'h0;
    idx = 0; cyc = 0; last_t = -1;
    z_rsp_ready = 1'b1;
    @(negedge clk);
    while ((idx < 9 || exp_q.size() > 0) && cyc < 100) begin
      if (z_rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $error("FAIL z_extra_rsp observed=%h expected=none", z_rsp_rdata);
        end else begin
          chk("z_rdata", z_rsp_rdata, exp_q.pop_front());
          chk("z_err", 32'(z_rsp_err), exp_err_q.pop_front());
          if (last_t >= 0) chk("z_spacing", 32'(cyc - last_t), 32'd2);
          last_t = cyc;
        end
      end
      if (z_req_ready && idx < 9) begin
        z_req_valid = 1'b1; z_req_we = t_we[idx]; z_req_addr = t_addr[idx];
        z_req_wdata = t_wd[idx]; z_req_be = 4'hF;
        if (addr_err(t_addr[idx])) begin
          exp_q.push_back(32'd0);
          exp_err_q.push_back(32'd1);
        end else begin
          exp_q.push_back(t_we[idx] ? 32'd0 : zd[t_addr[idx][3:2]]);
          exp_err_q.push_back(32'd0);
        end
        idx++;
      end else if (idx >= 9) begin
        z_req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("z_all_issued", 32'(idx), 32'd9);
    chk("z_all_responded", 32'(exp_q.size()), 32'd0);
    chk("z_stream_cycles", 32'(cyc), 32'd18);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
